// File: rtl/icosoc_rs232_frame_rx.sv
// Ctrl-bus master for the icosoc rs232 register file: polls the receive count, pops bytes, decodes
// SYNC/LEN/PAYLOAD/CSUM frames, answers ACK/NAK and streams good payloads on a valid/ready port.
module icosoc_rs232_frame_rx #(
  parameter int MAX_LEN       = 64,
  parameter int POLL_INTERVAL = 64,
  parameter int BYTE_TIMEOUT  = 60000,
  parameter bit ENABLE_ACK    = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  output logic [3:0]  ctrl_wr,
  output logic        ctrl_rd,
  output logic [15:0] ctrl_addr,
  output logic [31:0] ctrl_wdat,
  input  logic [31:0] ctrl_rdat,
  input  logic        ctrl_done,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_last,
  input  logic        m_ready,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic [4:0]  dbg_state
);
  localparam int AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int DEPTH = 1 << AW;
  localparam int WCW   = $clog2(POLL_INTERVAL + 1);
  localparam int TCW   = $clog2(BYTE_TIMEOUT + 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(POLL_INTERVAL - 1);
  localparam logic [TCW-1:0] TMO_LAST  = TCW'(BYTE_TIMEOUT - 1);
  localparam logic [7:0] MAX_LEN_B = MAX_LEN[7:0];
  localparam logic [7:0] SYNC = 8'hA5, ACK = 8'h06, NAK = 8'h15;

  typedef enum logic [2:0] {B_WAIT, B_RD_CNT, B_RD_DATA, B_ACK_POLL, B_ACK_WR, B_DRAIN} bus_state_t;
  typedef enum logic [1:0] {P_HUNT, P_LEN, P_DATA, P_CSUM} parse_state_t;

  bus_state_t   bus_q, bus_d;
  parse_state_t parse_q, parse_d;
  logic         req_on, req_on_d, req_done, byte_fire;
  logic         good_v, nak_v, tmo_v;
  logic [1:0]   code_v;
  logic [7:0]   rbyte, sum_add;
  logic [WCW-1:0] wait_cnt;
  logic [TCW-1:0] tmo_cnt;
  logic [7:0]   n_cnt, len_q, idx_q, sum_q, drain_idx, ack_byte;
  logic         ack_good;
  logic [1:0]   err_code_q;
  logic [7:0]   pay_buf [DEPTH];
  logic         unused_rdat;

  assign rbyte       = ctrl_rdat[7:0];
  assign unused_rdat = ^ctrl_rdat[31:8];
  assign sum_add     = sum_q + rbyte;
  assign req_done    = req_on & ctrl_done;
  assign byte_fire   = req_done & (bus_q == B_RD_DATA);
  assign err_code    = err_code_q;
  assign dbg_state   = {parse_q, bus_q};

  function automatic logic is_req(input bus_state_t s);
    return s inside {B_RD_CNT, B_RD_DATA, B_ACK_POLL, B_ACK_WR};
  endfunction

  always_ff @(posedge clk) begin
    if (!resetn) begin
      bus_q   <= B_WAIT;
      parse_q <= P_HUNT;
      req_on  <= 1'b0;
    end else begin
      bus_q   <= bus_d;
      parse_q <= parse_d;
      req_on  <= req_on_d;
    end
  end

  // Parser: a consumed byte always wins over a timeout landing in the same cycle.
  always_comb begin
    parse_d = parse_q;
    good_v  = 1'b0;
    nak_v   = 1'b0;
    tmo_v   = 1'b0;
    code_v  = 2'd0;
    if (byte_fire) begin
      case (parse_q)
        P_HUNT: if (rbyte == SYNC) parse_d = P_LEN;
        P_LEN: begin
          if (rbyte > MAX_LEN_B) begin
            nak_v   = 1'b1;
            code_v  = 2'd2;
            parse_d = P_HUNT;
          end else begin
            parse_d = (rbyte == 8'd0) ? P_CSUM : P_DATA;
          end
        end
        P_DATA: if (idx_q == len_q - 8'd1) parse_d = P_CSUM;
        P_CSUM: begin
          parse_d = P_HUNT;
          if (sum_add == 8'd0) begin
            good_v = 1'b1;
          end else begin
            nak_v  = 1'b1;
            code_v = 2'd1;
          end
        end
        default: parse_d = P_HUNT;
      endcase
    end else if (parse_q != P_HUNT && tmo_cnt == TMO_LAST) begin
      tmo_v   = 1'b1;
      code_v  = 2'd3;
      parse_d = P_HUNT;
    end
  end

  // Bus: a request drops on the edge that samples ctrl_done, so back-to-back requests get one idle cycle.
  always_comb begin
    bus_d = bus_q;
    case (bus_q)
      B_WAIT:   if (wait_cnt == WAIT_LAST) bus_d = B_RD_CNT;
      B_RD_CNT: if (req_done) bus_d = (rbyte == 8'd0) ? B_WAIT : B_RD_DATA;
      B_RD_DATA: begin
        if (byte_fire) begin
          if (good_v || nak_v)
            bus_d = ENABLE_ACK ? B_ACK_POLL : ((good_v && len_q != 8'd0) ? B_DRAIN : B_RD_CNT);
          else if (n_cnt == 8'd1)
            bus_d = B_RD_CNT;
        end
      end
      B_ACK_POLL: if (req_done && rbyte != 8'd0) bus_d = B_ACK_WR;
      B_ACK_WR:   if (req_done) bus_d = (ack_good && len_q != 8'd0) ? B_DRAIN : B_RD_CNT;
      B_DRAIN:    if (m_ready && drain_idx == len_q - 8'd1) bus_d = B_RD_CNT;
      default:    bus_d = B_WAIT;
    endcase
    req_on_d = req_done ? 1'b0 : (req_on | is_req(bus_d));
  end

  // m_valid/m_data/m_last are held until a cycle with m_valid && m_ready; that cycle moves to the next beat.
  always_comb begin
    ctrl_rd   = req_on && (bus_q inside {B_RD_CNT, B_RD_DATA, B_ACK_POLL});
    ctrl_wr   = (req_on && bus_q == B_ACK_WR) ? 4'hf : 4'h0;
    ctrl_wdat = (req_on && bus_q == B_ACK_WR) ? {24'h0, ack_byte} : 32'h0;
    ctrl_addr = 16'h0;
    if (req_on && bus_q == B_RD_CNT)   ctrl_addr = 16'h4;
    if (req_on && bus_q == B_ACK_POLL) ctrl_addr = 16'h8;
    m_valid   = (bus_q == B_DRAIN);
    m_data    = m_valid ? pay_buf[drain_idx[AW-1:0]] : 8'h0;
    m_last    = m_valid && (drain_idx == len_q - 8'd1);
    frame_ok  = good_v;
    frame_err = nak_v | tmo_v;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wait_cnt   <= '0;
      tmo_cnt    <= '0;
      n_cnt      <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      sum_q      <= '0;
      drain_idx  <= '0;
      ack_good   <= 1'b0;
      ack_byte   <= '0;
      err_code_q <= '0;
      for (int i = 0; i < DEPTH; i++) pay_buf[i] <= '0;
    end else begin
      wait_cnt <= (bus_q == B_WAIT && wait_cnt != WAIT_LAST) ? wait_cnt + 1'b1 : '0;
      if (byte_fire || parse_q == P_HUNT) tmo_cnt <= '0;
      else if (tmo_cnt != TMO_LAST)       tmo_cnt <= tmo_cnt + 1'b1;
      if (req_done && bus_q == B_RD_CNT) n_cnt <= rbyte;
      else if (byte_fire)                n_cnt <= n_cnt - 8'd1;
      if (byte_fire) begin
        case (parse_q)
          P_LEN: begin
            len_q <= rbyte;
            sum_q <= rbyte;
            idx_q <= '0;
          end
          P_DATA: begin
            pay_buf[idx_q[AW-1:0]] <= rbyte;
            sum_q <= sum_add;
            idx_q <= idx_q + 8'd1;
          end
          default: ;
        endcase
      end
      if (good_v || nak_v) begin
        ack_good <= good_v;
        ack_byte <= good_v ? ACK : NAK;
      end
      if (nak_v || tmo_v) err_code_q <= code_v;
      if (bus_q != B_DRAIN) drain_idx <= '0;
      else if (m_ready)     drain_idx <= drain_idx + 8'd1;
    end
  end
endmodule

// File: tb/tb_icosoc_rs232_frame_rx.sv
// Directed bench: a small UART register-file model answers the ctrl bus; frames and expected
// ACK/NAK bytes, error codes and payload beats are written out by hand.
module tb_icosoc_rs232_frame_rx;
  localparam int MAX_LEN = 64;
  localparam int POLL    = 16;
  localparam int BT      = 400;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [3:0]  ctrl_wr;
  logic        ctrl_rd;
  logic [15:0] ctrl_addr;
  logic [31:0] ctrl_wdat;
  logic [31:0] ctrl_rdat = 32'h0;
  logic        ctrl_done = 1'b0;
  logic [7:0]  m_data;
  logic        m_valid, m_last;
  logic        m_ready = 1'b1;
  logic        frame_ok, frame_err;
  logic [1:0]  err_code;
  logic [4:0]  dbg_state;

  icosoc_rs232_frame_rx #(.MAX_LEN(MAX_LEN), .POLL_INTERVAL(POLL), .BYTE_TIMEOUT(BT), .ENABLE_ACK(1'b1)) dut (
    .clk(clk), .resetn(resetn),
    .ctrl_wr(ctrl_wr), .ctrl_rd(ctrl_rd), .ctrl_addr(ctrl_addr), .ctrl_wdat(ctrl_wdat),
    .ctrl_rdat(ctrl_rdat), .ctrl_done(ctrl_done),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [7:0]  rx_q[$];
  logic [7:0]  sf_q[$];
  logic [7:0]  wr_q[$];
  logic [8:0]  got_q[$];
  logic [8:0]  exp_q[$];
  int          gap_q[$];
  int          n_checks = 0, n_fail = 0;
  int          n_rd00 = 0, n_rd04 = 0, n_rd08 = 0, n_ok = 0, n_err = 0;
  int          last_done_cyc = 0, last_rd00_cyc = 0, last_rd08_cyc = 0, last_wr_cyc = 0, last_err_cyc = 0;
  logic [15:0] last_done_addr = 16'hffff;
  logic [7:0]  last_done_val = 8'hff;
  bit          toggle_ready = 1'b0;
  int          b_ok, b_err, b_rd08;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic run_cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic snap();
    b_ok = n_ok; b_err = n_err; b_rd08 = n_rd08;
    wr_q.delete(); got_q.delete(); exp_q.delete();
  endtask

  task automatic compare_beats(input string tag);
    check({tag, "_beats"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check({tag, "_beat"}, (i < got_q.size()) ? {23'h0, got_q[i]} : 32'hffff_ffff, {23'h0, exp_q[i]});
  endtask

  // driver: UART register-file responder, one-cycle latency, garbage in rdat[31:8]
  initial begin
    int lat;
    int v;
    lat = 0;
    forever begin
      @(negedge clk);
      ctrl_done = 1'b0;
      m_ready = toggle_ready ? ~m_ready : 1'b1;
      if (!resetn || (!ctrl_rd && ctrl_wr == 4'h0)) begin
        lat = 0;
      end else if (lat == 0) begin
        lat = 1;
        if (ctrl_rd && ctrl_addr == 16'h4 && last_done_addr == 16'h4 && last_done_val == 8'h0)
          gap_q.push_back(cyc - last_done_cyc);
      end else begin
        lat = 0;
        ctrl_done = 1'b1;
        last_done_cyc = cyc;
        last_done_addr = ctrl_addr;
        if (ctrl_wr != 4'h0) begin
          check("wr_addr", {16'h0, ctrl_addr}, 32'h0);
          check("wr_strb", {28'h0, ctrl_wr}, 32'hf);
          check("wr_hi", {8'h0, ctrl_wdat[31:8]}, 32'h0);
          wr_q.push_back(ctrl_wdat[7:0]);
          last_wr_cyc = cyc;
          last_done_val = 8'hff;
        end else begin
          v = 0;
          case (ctrl_addr)
            16'h4: begin n_rd04++; v = (rx_q.size() > 255) ? 255 : rx_q.size(); end
            16'h0: begin n_rd00++; v = (rx_q.size() != 0) ? int'(rx_q.pop_front()) : 0; last_rd00_cyc = cyc; end
            16'h8: begin n_rd08++; v = (sf_q.size() != 0) ? int'(sf_q.pop_front()) : 8; last_rd08_cyc = cyc; end
            default: v = 0;
          endcase
          ctrl_rdat = {24'hc0ffee, v[7:0]};
          last_done_val = v[7:0];
        end
      end
    end
  end

  // monitor: verdict pulses, payload beats, hold-while-stalled
  initial begin
    bit stalled;
    logic [8:0] stall_beat;
    stalled = 1'b0;
    stall_beat = '0;
    forever begin
      @(negedge clk);
      #2;
      if (resetn) begin
        if (frame_ok) n_ok++;
        if (frame_err) begin n_err++; last_err_cyc = cyc; end
        if (stalled) begin
          check("hold_valid", {31'h0, m_valid}, 32'h1);
          check("hold_beat", {23'h0, m_last, m_data}, {23'h0, stall_beat});
        end
        stalled = m_valid && !m_ready;
        stall_beat = {m_last, m_data};
        if (m_valid && m_ready) got_q.push_back({m_last, m_data});
      end else begin
        stalled = 1'b0;
      end
    end
  end

  initial begin
    bit seen;
    // reset state
    resetn = 1'b0;
    run_cycles(4);
    @(negedge clk); #3;
    check("rst_rd", {31'h0, ctrl_rd}, 32'h0);
    check("rst_wr", {28'h0, ctrl_wr}, 32'h0);
    check("rst_addr", {16'h0, ctrl_addr}, 32'h0);
    check("rst_valid", {31'h0, m_valid}, 32'h0);
    check("rst_pulses", {30'h0, frame_ok, frame_err}, 32'h0);
    check("rst_code", {30'h0, err_code}, 32'h0);
    check("rst_state", {27'h0, dbg_state}, 32'h0);
    resetn = 1'b1;

    // 1: empty UART, polls spaced by POLL idle cycles, no data reads
    run_cycles(90);
    check("poll_n", (gap_q.size() >= 3) ? 32'h1 : 32'h0, 32'h1);
    for (int i = 0; i < gap_q.size(); i++) check("poll_gap", gap_q[i], POLL + 1);
    check("poll_rd00", n_rd00, 0);

    // 2: good frame, consumer always ready
    snap();
    rx_q = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
    exp_q = {9'h011, 9'h022, 9'h133};
    run_cycles(150);
    check("t2_ok", n_ok - b_ok, 1);
    check("t2_err", n_err - b_err, 0);
    check("t2_rd08", n_rd08 - b_rd08, 1);
    check("t2_wr_n", wr_q.size(), 1);
    check("t2_wr", (wr_q.size() != 0) ? {24'h0, wr_q[0]} : 32'hffff, 32'h06);
    check("t2_order", (last_rd08_cyc < last_wr_cyc) ? 32'h1 : 32'h0, 32'h1);
    compare_beats("t2");

    // 2b: same frame, consumer toggling ready
    snap();
    toggle_ready = 1'b1;
    rx_q = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
    exp_q = {9'h011, 9'h022, 9'h133};
    run_cycles(150);
    toggle_ready = 1'b0;
    check("t2b_ok", n_ok - b_ok, 1);
    check("t2b_wr", (wr_q.size() != 0) ? {24'h0, wr_q[0]} : 32'hffff, 32'h06);
    compare_beats("t2b");

    // 3: bad checksum
    snap();
    rx_q = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h98};
    run_cycles(150);
    check("t3_ok", n_ok - b_ok, 0);
    check("t3_err", n_err - b_err, 1);
    check("t3_code", {30'h0, err_code}, 32'h1);
    check("t3_wr_n", wr_q.size(), 1);
    check("t3_wr", (wr_q.size() != 0) ? {24'h0, wr_q[0]} : 32'hffff, 32'h15);
    compare_beats("t3");

    // 4: junk then empty frame; then over-length LEN
    snap();
    rx_q = {8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00};
    run_cycles(150);
    check("t4_ok", n_ok - b_ok, 1);
    check("t4_err", n_err - b_err, 0);
    check("t4_wr", (wr_q.size() != 0) ? {24'h0, wr_q[0]} : 32'hffff, 32'h06);
    compare_beats("t4");
    snap();
    rx_q = {8'hA5, 8'h41};
    run_cycles(150);
    check("t4b_err", n_err - b_err, 1);
    check("t4b_code", {30'h0, err_code}, 32'h2);
    check("t4b_wr", (wr_q.size() != 0) ? {24'h0, wr_q[0]} : 32'hffff, 32'h15);

    // 5: silence inside a frame, then recovery
    snap();
    rx_q = {8'hA5, 8'h02, 8'h11};
    run_cycles(BT + 80);
    check("t5_err", n_err - b_err, 1);
    check("t5_code", {30'h0, err_code}, 32'h3);
    check("t5_time", last_err_cyc - last_rd00_cyc, BT);
    check("t5_wr_n", wr_q.size(), 0);
    snap();
    rx_q = {8'hA5, 8'h01, 8'h7F, 8'h80};
    exp_q = {9'h17F};
    run_cycles(150);
    check("t5b_ok", n_ok - b_ok, 1);
    check("t5b_wr", (wr_q.size() != 0) ? {24'h0, wr_q[0]} : 32'hffff, 32'h06);
    compare_beats("t5b");

    // 6: send FIFO full three times before the ACK fits
    snap();
    sf_q = {8'h00, 8'h00, 8'h00, 8'h05};
    rx_q = {8'hA5, 8'h00, 8'h00};
    run_cycles(150);
    check("t6_rd08", n_rd08 - b_rd08, 4);
    check("t6_wr_n", wr_q.size(), 1);
    check("t6_wr", (wr_q.size() != 0) ? {24'h0, wr_q[0]} : 32'hffff, 32'h06);

    // 6b: reset while a data read is outstanding
    rx_q = {8'hA5, 8'h05, 8'h01, 8'h02, 8'h03};
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk); #3;
      if (ctrl_rd && ctrl_addr == 16'h0) seen = 1'b1;
    end
    check("t6b_seen", {31'h0, seen}, 32'h1);
    resetn = 1'b0;
    @(posedge clk);
    @(negedge clk); #3;
    check("t6b_rd", {31'h0, ctrl_rd}, 32'h0);
    check("t6b_wr", {28'h0, ctrl_wr}, 32'h0);
    check("t6b_addr", {16'h0, ctrl_addr}, 32'h0);
    check("t6b_valid", {31'h0, m_valid}, 32'h0);
    check("t6b_state", {27'h0, dbg_state}, 32'h0);
    rx_q.delete();
    @(negedge clk);
    resetn = 1'b1;
    snap();
    rx_q = {8'h01, 8'hA5, 8'h01, 8'h7F, 8'h80};
    exp_q = {9'h17F};
    run_cycles(150);
    check("t6c_ok", n_ok - b_ok, 1);
    check("t6c_err", n_err - b_err, 0);
    compare_beats("t6c");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
